// File: rtl/bulls_cows_engine_pkg.sv
// Shared types and width helpers for the bulls-and-cows scoring engine.
package bc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        SCORE = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } bc_state_t;

    // Width of a hit counter that must hold 0..n_digits.
    function automatic int bc_cw(input int n_digits);
        return $clog2(n_digits + 1);
    endfunction

    // Width of the try counter that must hold 0..max_tries.
    function automatic int bc_tw(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

endpackage

// File: rtl/bulls_cows_engine_if.sv
// Strobe/switch inputs and display-facing outputs of the scoring engine.
interface bulls_cows_engine_if #(
    parameter int N_DIGITS  = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 17
);
    localparam int CW   = bc_pkg::bc_cw(N_DIGITS);
    localparam int TW   = bc_pkg::bc_tw(MAX_TRIES);
    localparam int SW_W = N_DIGITS * DIGIT_W;

    logic            start;
    logic            submit;
    logic            abort;
    logic [SW_W-1:0] sw;
    logic [2:0]      state;
    logic            busy;
    logic            score_valid;
    logic [CW-1:0]   a_cnt;
    logic [CW-1:0]   b_cnt;
    logic [TW-1:0]   tries;
    logic [SW_W-1:0] guess_q;
    logic            inv_err;

    modport master (
        output start, submit, abort, sw,
        input  state, busy, score_valid, a_cnt, b_cnt, tries, guess_q, inv_err
    );

    modport slave (
        input  start, submit, abort, sw,
        output state, busy, score_valid, a_cnt, b_cnt, tries, guess_q, inv_err
    );

endinterface

// File: rtl/bulls_cows_engine_digit_check.sv
// Combinational validity check of a digit bus: every digit in range, all distinct.
module bc_digit_check #(
    parameter int N_DIGITS  = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_DIGIT = 9
) (
    input  logic [N_DIGITS*DIGIT_W-1:0] sw_i,
    output logic                        valid_o
);

    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

    // Range test per digit plus a pairwise inequality test over all digit pairs
    always_comb begin
        valid_o = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            valid_o = valid_o & (sw_i[i*DIGIT_W +: DIGIT_W] <= MAX_D);
            for (int j = i + 1; j < N_DIGITS; j++) begin
                valid_o = valid_o &
                          (sw_i[i*DIGIT_W +: DIGIT_W] != sw_i[j*DIGIT_W +: DIGIT_W]);
            end
        end
    end

endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls-and-cows game engine: secret/guess validation, iterative digit scoring,
// try limit and abort. One guess digit is scored per cycle in SCORE.
module bulls_cows_engine #(
    parameter int N_DIGITS  = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_DIGIT = 9,
    parameter int MAX_TRIES = 17
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bulls_cows_engine_if.slave     bus
);
    import bc_pkg::*;

    localparam int CW   = bc_cw(N_DIGITS);
    localparam int TW   = bc_tw(MAX_TRIES);
    localparam int KW   = $clog2(N_DIGITS);
    localparam int SW_W = N_DIGITS * DIGIT_W;

    bc_state_t       state_q;
    logic [SW_W-1:0] secret_q;
    logic [SW_W-1:0] guess_q;
    logic [KW-1:0]   k_q;
    logic [CW-1:0]   a_acc_q;
    logic [CW-1:0]   b_acc_q;
    logic [CW-1:0]   a_cnt_q;
    logic [CW-1:0]   b_cnt_q;
    logic [TW-1:0]   tries_q;
    logic            score_valid_q;
    logic            inv_err_q;
    logic            busy_q;

    logic            sw_valid_s;
    logic [DIGIT_W-1:0] g_dig_s;
    logic            hit_a_s;
    logic            hit_b_s;
    logic [CW-1:0]   a_next_s;
    logic [CW-1:0]   b_next_s;
    logic [TW-1:0]   tries_inc_s;
    logic            last_s;

    // start and submit are never acted on in the same cycle, so one checker serves both
    bc_digit_check #(
        .N_DIGITS  (N_DIGITS),
        .DIGIT_W   (DIGIT_W),
        .MAX_DIGIT (MAX_DIGIT)
    ) u_check (
        .sw_i    (bus.sw),
        .valid_o (sw_valid_s)
    );

    // Select the guess digit currently being scored
    always_comb begin
        g_dig_s = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (KW'(i) == k_q) begin
                g_dig_s = guess_q[i*DIGIT_W +: DIGIT_W];
            end else begin
                g_dig_s = g_dig_s;
            end
        end
    end

    // Compare the selected guess digit with every secret digit (secret digits are distinct)
    always_comb begin
        hit_a_s = 1'b0;
        hit_b_s = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            hit_a_s = hit_a_s | ((secret_q[i*DIGIT_W +: DIGIT_W] == g_dig_s) && (KW'(i) == k_q));
            hit_b_s = hit_b_s | ((secret_q[i*DIGIT_W +: DIGIT_W] == g_dig_s) && (KW'(i) != k_q));
        end
    end

    assign a_next_s    = a_acc_q + CW'(hit_a_s);
    assign b_next_s    = b_acc_q + CW'(hit_b_s);
    assign tries_inc_s = tries_q + TW'(1);
    assign last_s      = (k_q == KW'(N_DIGITS - 1));

    // Game FSM with registered outputs; abort overrides everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            secret_q      <= '0;
            guess_q       <= '0;
            k_q           <= '0;
            a_acc_q       <= '0;
            b_acc_q       <= '0;
            a_cnt_q       <= '0;
            b_cnt_q       <= '0;
            tries_q       <= '0;
            score_valid_q <= 1'b0;
            inv_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            score_valid_q <= 1'b0;
            inv_err_q     <= 1'b0;
            if (bus.abort) begin
                state_q <= IDLE;
                k_q     <= '0;
                a_acc_q <= '0;
                b_acc_q <= '0;
                a_cnt_q <= '0;
                b_cnt_q <= '0;
                tries_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, WIN, LOSE: begin
                        if (bus.start) begin
                            if (sw_valid_s) begin
                                secret_q <= bus.sw;
                                tries_q  <= '0;
                                a_cnt_q  <= '0;
                                b_cnt_q  <= '0;
                                state_q  <= PLAY;
                            end else begin
                                inv_err_q <= 1'b1;
                                state_q   <= IDLE;
                            end
                        end else begin
                            state_q <= state_q;
                        end
                    end
                    PLAY: begin
                        if (bus.submit) begin
                            if (sw_valid_s) begin
                                guess_q <= bus.sw;
                                k_q     <= '0;
                                a_acc_q <= '0;
                                b_acc_q <= '0;
                                busy_q  <= 1'b1;
                                state_q <= SCORE;
                            end else begin
                                inv_err_q <= 1'b1;
                            end
                        end else begin
                            state_q <= PLAY;
                        end
                    end
                    SCORE: begin
                        a_acc_q <= a_next_s;
                        b_acc_q <= b_next_s;
                        if (last_s) begin
                            k_q           <= '0;
                            a_cnt_q       <= a_next_s;
                            b_cnt_q       <= b_next_s;
                            tries_q       <= tries_inc_s;
                            score_valid_q <= 1'b1;
                            busy_q        <= 1'b0;
                            if (a_next_s == CW'(N_DIGITS)) begin
                                state_q <= WIN;
                            end else if (tries_inc_s == TW'(MAX_TRIES)) begin
                                state_q <= LOSE;
                            end else begin
                                state_q <= PLAY;
                            end
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.busy        = busy_q;
    assign bus.score_valid = score_valid_q;
    assign bus.a_cnt       = a_cnt_q;
    assign bus.b_cnt       = b_cnt_q;
    assign bus.tries       = tries_q;
    assign bus.guess_q     = guess_q;
    assign bus.inv_err     = inv_err_q;

endmodule

// File: doc/bulls_cows_engine.md
# bulls_cows_engine

Parametrised 1A2B (bulls-and-cows) scoring engine for the DE2 game builds. The top level feeds it debounced single-cycle strobes and the switch bank; it drives the HEX/LED display logic from its state, score and try count. It supersedes the fixed 4-digit, combinational-scoring game logic and adds:

- configurable digit count, digit range and try limit;
- rejection of invalid secrets and guesses;
- iterative scoring with a busy/valid handshake;
- a synchronous abort.

## Interface
Parameters:
- N_DIGITS, default 4: digits per secret/guess, range 2..8.
- DIGIT_W, default 4: bits per digit.
- MAX_DIGIT, default 9: largest legal digit value.
- MAX_TRIES, default 17: scored guesses allowed before LOSE, minimum 1.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle strobe: load secret from sw and begin a game.
- submit  in  1  one-cycle strobe: score sw as a guess.
- abort  in  1  one-cycle strobe: return to IDLE.
- sw  in  N_DIGITS*DIGIT_W  digit bus; digit 0 in the LSBs.
- state  out  3  current state encoding, from the package enum.
- busy  out  1  high while in SCORE.
- score_valid  out  1  one-cycle pulse when a_cnt/b_cnt/tries are updated.
- a_cnt  out  CW = $clog2(N_DIGITS+1)  exact-position matches of the last scored guess.
- b_cnt  out  CW  wrong-position matches of the last scored guess.
- tries  out  TW = $clog2(MAX_TRIES+1)  scored guesses this game.
- guess_q  out  N_DIGITS*DIGIT_W  last accepted guess, for display.
- inv_err  out  1  one-cycle pulse: the strobed sw value was invalid.

## Operation
- Reset (rst_n low): state = IDLE; all other outputs and internal registers are 0.

Validity rule:
- All N_DIGITS digits ≤ MAX_DIGIT.
- No two digits equal.
- Applies to both secrets and guesses.

States:
- IDLE, start:
  - sw valid → latch secret, clear tries/a_cnt/b_cnt, go to PLAY.
  - sw invalid → pulse inv_err, stay in IDLE.
- PLAY, submit:
  - sw valid → latch guess_q, clear the accumulators, go to SCORE.
  - sw invalid → pulse inv_err; tries and state are unchanged.
- SCORE: digit index k = 0..N_DIGITS-1, one per cycle.
  - Guess digit k equals secret digit k → A accumulator += 1.
  - Otherwise, guess digit k equals any other secret digit → B accumulator += 1.
  - After digit N_DIGITS-1, the next edge does all of the following together: write a_cnt/b_cnt, tries += 1, pulse score_valid, and move to the next state:
    - WIN if A == N_DIGITS;
    - else LOSE if tries (new value) == MAX_TRIES;
    - else PLAY.
- WIN / LOSE: outputs are held. start behaves exactly as it does in IDLE (revalidate and reload, or pulse inv_err and go to IDLE).

Strobe handling:
- submit in IDLE, SCORE, WIN or LOSE is ignored.
- start in PLAY or SCORE is ignored.
- abort in any state → IDLE on the next edge, with tries/a_cnt/b_cnt/accumulators cleared and no score_valid.
- Priority when strobes coincide: abort > start > submit. inv_err is never raised on an abort cycle.
- sw is sampled only on strobe cycles; it may change freely during SCORE.

## Timing
- Submit strobe at edge t:
  - state = SCORE and busy = 1 from t+1;
  - score_valid = 1 during cycle t+N_DIGITS+1;
  - busy = 0 from t+N_DIGITS+1.
- inv_err is high during cycle t+1 only.
- Start: state = PLAY from t+1.
- Reset is asynchronous: asserting rst_n mid-SCORE zeroes all outputs immediately; release is synchronous to clk.
- No combinational path from inputs to outputs.

## Structure
- Package bc_pkg:
  - bc_state_t enum: IDLE=0, PLAY=1, SCORE=2, WIN=3, LOSE=4;
  - width helper functions for CW and TW.
- Sub-module bc_digit_check: purely combinational range/duplicate checker (sw → valid). It is instantiated once and shared by start and submit, since the two are never acted on in the same cycle.
- Scoring uses one digit comparator against the N_DIGITS secret digits per cycle; no full N×N parallel array.

## Test plan
All scenarios use the default parameters.
1. Secret 1234 via start; submit 1234 → score_valid at t+5, a_cnt=4, b_cnt=0, tries=1, state=WIN.
2. Secret 1234; submit 4321 → a_cnt=0, b_cnt=4, state=PLAY. Then submit 1243 → a_cnt=2, b_cnt=2, tries=2.
3. Invalid inputs:
   - start with secret 1123 → inv_err at t+1, state stays IDLE.
   - in PLAY, submit 12A4 → inv_err, tries unchanged, no score_valid.
4. Try limit: secret 1234; 17 submits of 5678 → a_cnt=0, b_cnt=0 each time; state=LOSE with tries=17 after the 17th score_valid; an 18th submit is ignored.
5. Mid-SCORE interruptions:
   - abort at t+2 → state=IDLE at t+3, no score_valid, tries=0;
   - start and submit together in PLAY → start ignored, scoring proceeds;
   - rst_n low mid-SCORE → all outputs 0 asynchronously.
6. Restart from WIN: start with secret 9087 → state=PLAY, tries=0. Submit 7089 → a_cnt=2, b_cnt=2.
